dcache_sram_nway: RTL and testbench
===================================

# dcache_sram_nway

Parametrised N-way set-associative data-cache storage array with per-set true-LRU age counters and a hardware invalidate-all sweep. It sits between the dcache controller and its backing memory interface as the successor to the fixed 2-way, 16-set array. The controller presents index, tag and line on one port. The array returns hit status, the hit line, or on a miss the victim line for write-back. A flush request clears every valid bit in SETS cycles while the array reports busy.

## Interface
Parameters:
- WAYS, 2: associativity; power of two, 2..8.
- SETS, 16: number of sets; power of two, 2..256.
- TAG_W, 25: tag entry width; bit TAG_W-1 = valid, bit TAG_W-2 = dirty, bits TAG_W-3:0 = cpu tag.
- LINE_W, 256: cache line width in bits.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- addr_i  in  log2(SETS)  set index.
- tag_i  in  TAG_W  {valid, dirty, cpu_tag} for compare and write.
- data_i  in  LINE_W  line to write.
- enable_i  in  1  access request.
- write_i  in  1  1 = write or fill, 0 = read.
- flush_i  in  1  start the invalidate-all sweep; single-cycle pulse.
- tag_o  out  TAG_W  hit way's tag, else victim way's tag.
- data_o  out  LINE_W  hit way's line, else victim way's line.
- hit_o  out  1  lookup hit.
- way_o  out  log2(WAYS)  hit way, else victim way.
- busy_o  out  1  sweep in progress; accesses are ignored.

## Operation
- Hit in way w: tag[set][w] valid bit = 1 and cpu tag bits equal tag_i[TAG_W-3:0]. The dirty bit is excluded from the compare. At most one way hits; if more than one does, the lowest index wins.
- Victim selection: the lowest-index invalid way. If every way in the set is valid, the way whose age = WAYS-1.
- Age state: each set holds a permutation of ages 0..WAYS-1 (0 = MRU).
- Touch of way w (old age a): age[w] <= 0, and every way with age < a increments by 1. Other ages are unchanged, so the permutation is preserved.
- Access with enable_i=1 and busy_o=0:
  - Read hit: touch the hit way. No data or tag change.
  - Read miss: no state change. Outputs show the victim so the controller can write back a dirty line.
  - Write hit: tag and data of the hit way <= tag_i, data_i; touch that way.
  - Write miss (fill): tag and data of the victim way <= tag_i, data_i; touch that way.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on flush_i=1; sweep counter <= 0.
  - In SWEEP, each cycle: valid bits of all ways in set[counter] <= 0, ages <= way index, counter increments.
  - SWEEP -> IDLE after the cycle that clears set SETS-1.
  - Dirty lines are discarded by the sweep. Write-back before flushing is the controller's job.
- During SWEEP: enable_i and flush_i are ignored, and hit_o is forced to 0.
- flush_i and enable_i together in IDLE: the access completes on that edge, then the sweep starts, so the accessed line is invalidated by the sweep.

## Timing
- Lookup is combinational: hit_o, way_o, tag_o and data_o are valid in the same cycle as addr_i and tag_i.
- Writes and age updates land on the rising edge; a read in the following cycle sees the new values.
- busy_o is registered. It rises on the edge that samples flush_i and stays high for exactly SETS cycles.
- Reset values: all tags 0, all data 0, age[s][w] = w, FSM = IDLE, counter = 0, busy_o = 0. With every set invalid, hit_o = 0 and way_o = 0.
- Reset asserted mid-sweep aborts the sweep immediately; busy_o = 0 asynchronously.
- Counter width is log2(SETS). Terminal count is SETS-1; the counter does not wrap back into a second sweep.

## Test plan
- Reset, then read set 5 with any tag -> hit_o=0, way_o=0, tag_o=0, data_o=0, busy_o=0.
- WAYS=4: fill set 3 with tags A,B,C,D (valid=1), then read A -> hit_o=1, way_o=0. Fill E -> replaces B (way 1). Read B -> hit_o=0.
- Write hit to way 2 with the dirty bit set, then read with the same cpu tag and dirty=0 -> hit_o=1, tag_o dirty bit = 1, data_o = written line.
- Read miss on a full set -> ages unchanged. Two consecutive read misses report the same way_o.
- SETS=16: pulse flush_i -> busy_o high for 16 cycles, enable_i ignored. Afterwards every previously filled line misses and ages = way index.
- Assert rst_i at sweep cycle 7 -> busy_o=0 at once, all sets invalid. A new flush_i after reset runs the full 16 cycles.

Source files
------------

// File: rtl/dcache_sram_nway_if.sv
// dcache_sram_nway_if: controller <-> N-way cache storage array bus.
//   master : the dcache controller (drives index/tag/line/strobes)
//   slave  : the storage array (returns hit, way, tag, line, busy)
// Signals:
//   addr_i   set index            tag_i   {valid, dirty, cpu_tag}
//   data_i   line to write        enable_i/write_i/flush_i  request strobes
//   tag_o    hit or victim tag    data_o  hit or victim line
//   hit_o    lookup hit           way_o   hit or victim way
//   busy_o   invalidate sweep in progress
interface dcache_sram_nway_if #(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int TAG_W  = 25,
    parameter int LINE_W = 256
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

    logic [IDX_W-1:0]  addr_i;
    logic [TAG_W-1:0]  tag_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic              flush_i;
    logic [TAG_W-1:0]  tag_o;
    logic [LINE_W-1:0] data_o;
    logic              hit_o;
    logic [WAY_W-1:0]  way_o;
    logic              busy_o;

    modport master (
        output addr_i, tag_i, data_i, enable_i, write_i, flush_i,
        input  tag_o, data_o, hit_o, way_o, busy_o
    );

    modport slave (
        input  addr_i, tag_i, data_i, enable_i, write_i, flush_i,
        output tag_o, data_o, hit_o, way_o, busy_o
    );
endinterface

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: parametrised N-way set-associative data-cache storage
// with per-set true-LRU age counters and an invalidate-all sweep.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    dcache_sram_nway_if.slave (see interface header)
// Lookup is combinational; writes, age updates and sweep clears land on
// the rising edge. While busy_o is high, accesses and flush are ignored.
module dcache_sram_nway #(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int TAG_W  = 25,
    parameter int LINE_W = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_sram_nway_if.slave   bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int CT_W  = TAG_W - 2;   // cpu tag width, excludes valid/dirty

    typedef enum logic {IDLE, SWEEP} state_e;

    // storage
    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [LINE_W-1:0] data_q [SETS][WAYS];
    logic [WAY_W-1:0]  age_q  [SETS][WAYS];

    // sweep FSM
    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // lookup
    logic [IDX_W-1:0] idx;
    logic             hit_raw, hit_eff;
    logic [WAY_W-1:0] hit_way, inv_way, lru_way, sel_way;
    logic             inv_found;
    logic [WAY_W-1:0] touch_age;
    logic [WAY_W-1:0] age_upd [WAYS];
    logic             acc_en, wr_en, touch_en;

    assign idx = bus.addr_i;

    always_comb begin
        hit_raw   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            // dirty bit deliberately excluded; lowest hitting way wins
            if (!hit_raw && tag_q[idx][w][TAG_W-1] &&
                tag_q[idx][w][CT_W-1:0] == bus.tag_i[CT_W-1:0]) begin
                hit_raw = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !tag_q[idx][w][TAG_W-1]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[idx][w] == WAY_W'(WAYS-1))
                lru_way = WAY_W'(w);
        end
        hit_eff = hit_raw && !busy_q;
        if (hit_eff)        sel_way = hit_way;
        else if (inv_found) sel_way = inv_way;
        else                sel_way = lru_way;
    end

    // Touch of sel_way: it becomes MRU, every younger way ages by one,
    // which keeps the set's ages a permutation of 0..WAYS-1.
    always_comb begin
        touch_age = age_q[idx][sel_way];
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == sel_way)          age_upd[w] = '0;
            else if (age_q[idx][w] < touch_age) age_upd[w] = age_q[idx][w] + 1'b1;
            else                                age_upd[w] = age_q[idx][w];
        end
    end

    assign acc_en   = bus.enable_i && (state_q == IDLE);
    assign wr_en    = acc_en && bus.write_i;
    assign touch_en = acc_en && (bus.write_i || hit_raw);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(SETS-1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Arrays are written through a single port: either the sweep clears
    // one whole set, or the access updates the addressed set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                    age_q[s][w]  <= WAY_W'(w);
                end
            end
        end else if (state_q == SWEEP) begin
            // dirty lines are dropped; only valid is cleared
            for (int w = 0; w < WAYS; w++) begin
                tag_q[cnt_q][w][TAG_W-1] <= 1'b0;
                age_q[cnt_q][w]          <= WAY_W'(w);
            end
        end else begin
            if (wr_en) begin
                tag_q[idx][sel_way]  <= bus.tag_i;
                data_q[idx][sel_way] <= bus.data_i;
            end
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++)
                    age_q[idx][w] <= age_upd[w];
            end
        end
    end

    assign bus.hit_o  = hit_eff;
    assign bus.way_o  = sel_way;
    assign bus.tag_o  = tag_q[idx][sel_way];
    assign bus.data_o = data_q[idx][sel_way];
    assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: scoreboard bench for dcache_sram_nway, WAYS=4,
// SETS=16, TAG_W=25, LINE_W=64. Expected lookups are queued when the read
// is driven and compared shortly after the driving falling edge.
module tb_dcache_sram_nway;
    localparam int WAYS = 4, SETS = 16, TAG_W = 25, LINE_W = 64;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    dcache_sram_nway_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

    dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        string       nm;
        bit          full;   // 0: only hit/busy are meaningful
        logic        hit;
        logic [1:0]  way;
        logic [24:0] tg;
        logic [63:0] dt;
        logic        bsy;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        #2;
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.nm, ".hit"},  64'(bus.hit_o),  64'(e.hit));
            chk({e.nm, ".busy"}, 64'(bus.busy_o), 64'(e.bsy));
            if (e.full) begin
                chk({e.nm, ".way"},  64'(bus.way_o),  64'(e.way));
                chk({e.nm, ".tag"},  64'(bus.tag_o),  64'(e.tg));
                chk({e.nm, ".data"}, bus.data_o,      e.dt);
            end
        end
    end

    function automatic logic [24:0] tg(input logic v, input logic d, input logic [22:0] t);
        return {v, d, t};
    endfunction

    function automatic logic [63:0] dat(input int n);
        return 64'hDA7A_0000_0000_0000 | 64'(n);
    endfunction

    task automatic cyc(input logic [3:0] idx, input logic [24:0] t, input logic [63:0] d,
                       input logic en, input logic wr, input logic fl);
        @(negedge clk_i);
        bus.addr_i   = idx;
        bus.tag_i    = t;
        bus.data_i   = d;
        bus.enable_i = en;
        bus.write_i  = wr;
        bus.flush_i  = fl;
    endtask

    task automatic expect_o(input string nm, input bit full, input logic h, input logic [1:0] w,
                            input logic [24:0] t, input logic [63:0] d, input logic b);
        exp_t e;
        e.nm = nm; e.full = full; e.hit = h; e.way = w; e.tg = t; e.dt = d; e.bsy = b;
        sb_q.push_back(e);
    endtask

    task automatic rd(input string nm, input logic [3:0] idx, input logic [24:0] t,
                      input logic h, input logic [1:0] w, input logic [24:0] et, input logic [63:0] ed);
        cyc(idx, t, '0, 1'b1, 1'b0, 1'b0);
        expect_o(nm, 1'b1, h, w, et, ed, 1'b0);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [24:0] t, input logic [63:0] d);
        cyc(idx, t, d, 1'b1, 1'b1, 1'b0);
    endtask

    logic [24:0] ta, tb_, tc, td, te, tf, tgg, th, tcd;

    initial begin
        ta  = tg(1, 0, 23'h0A); tb_ = tg(1, 0, 23'h0B); tc = tg(1, 0, 23'h0C);
        td  = tg(1, 0, 23'h0D); te  = tg(1, 0, 23'h0E); tf = tg(1, 0, 23'h0F);
        tgg = tg(1, 0, 23'h06); th  = tg(1, 0, 23'h07); tcd = tg(1, 1, 23'h0C);

        bus.addr_i = '0; bus.tag_i = '0; bus.data_i = '0;
        bus.enable_i = 0; bus.write_i = 0; bus.flush_i = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        rst_i = 1'b0;

        rd("rst_rd", 4'd5, tg(1, 0, 23'h55), 0, 2'd0, '0, '0);

        // fill set 3: empty ways are taken in index order
        wr(4'd3, ta, dat(1)); wr(4'd3, tb_, dat(2)); wr(4'd3, tc, dat(3)); wr(4'd3, td, dat(4));
        rd("hitA",  4'd3, ta, 1, 2'd0, ta, dat(1));         // ages -> [0,3,2,1]
        rd("missE", 4'd3, te, 0, 2'd1, tb_, dat(2));        // victim = B
        wr(4'd3, te, dat(5));                               // ages -> [1,0,3,2]
        rd("missB",  4'd3, tb_, 0, 2'd2, tc, dat(3));
        rd("missB2", 4'd3, tb_, 0, 2'd2, tc, dat(3));
        rd("hitE",   4'd3, te, 1, 2'd1, te, dat(5));
        wr(4'd3, tcd, dat(6));                              // write hit, dirty; ages -> [2,1,0,3]
        rd("dirty",  4'd3, tc, 1, 2'd2, tcd, dat(6));
        rd("lruD",   4'd3, tg(1, 0, 23'h77), 0, 2'd3, td, dat(4));
        wr(4'd9, tf, dat(7));
        rd("hitF",   4'd9, tf, 1, 2'd0, tf, dat(7));

        // flush together with a fill: the fill lands, then gets swept
        cyc(4'd7, tgg, dat(8), 1'b1, 1'b1, 1'b1);
        expect_o("fl_acc", 1'b1, 0, 2'd0, '0, '0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(4'd3, (i == 3) ? th : ta, dat(9), 1'b1, (i == 3) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0);
            if (i == 3) bus.addr_i = 4'd12;
            expect_o($sformatf("sweep%0d", i), 1'b0, 0, 2'd0, '0, '0, 1'b1);
        end
        rd("postA", 4'd3, ta,  0, 2'd0, tg(0, 0, 23'h0A), dat(1));
        rd("postE", 4'd3, te,  0, 2'd0, tg(0, 0, 23'h0A), dat(1));
        rd("postG", 4'd7, tgg, 0, 2'd0, tg(0, 0, 23'h06), dat(8));
        rd("postF", 4'd9, tf,  0, 2'd0, tg(0, 0, 23'h0F), dat(7));
        rd("noH",   4'd12, th, 0, 2'd0, '0, '0);
        rd("idle_noflush", 4'd5, ta, 0, 2'd0, '0, '0);

        // refill after flush and hit again
        wr(4'd3, tb_, dat(10));
        rd("refill", 4'd3, tb_, 1, 2'd0, tb_, dat(10));

        // reset in the middle of a sweep
        cyc(4'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(4'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("mid_busy", 64'(bus.busy_o), 64'd1);
        #1 rst_i = 1'b1;
        #1 chk("rst_abort", 64'(bus.busy_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd("rst_clr", 4'd3, tb_, 0, 2'd0, '0, '0);

        // full-length sweep after reset
        cyc(4'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        expect_o("fl2_pre", 1'b0, 0, 2'd0, '0, '0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(4'd0, '0, '0, 1'b0, 1'b0, 1'b0);
            expect_o($sformatf("sweep2_%0d", i), 1'b0, 0, 2'd0, '0, '0, 1'b1);
        end
        rd("fl2_done", 4'd0, ta, 0, 2'd0, '0, '0);

        cyc(4'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
